// File: rtl/imm_ext_ctrl_pkg.sv
// Shared constants and types for the ID-stage immediate sequencer.
package imm_ext_ctrl_pkg;

  // Default datapath widths. The extended output always holds two input bytes.
  localparam int IMM_IN_W  = 8;
  localparam int IMM_OUT_W = 16;

  // Extension modes as encoded by the decoder.
  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO = 2'b00;
  localparam ext_mode_t EXT_SIGN = 2'b01;
  localparam ext_mode_t EXT_HI   = 2'b10;
  localparam ext_mode_t EXT_SHL8 = 2'b11;

  // Sequencer states. PREFIX means a HI byte is held and waits for its low byte.
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_PREFIX = 1'b1;

  // A HI byte never produces a result by itself; it only loads the prefix.
  function automatic logic isPrefixMode(input ext_mode_t mode);
    return (mode == EXT_HI);
  endfunction

endpackage

// File: rtl/imm_ext_ctrl_if.sv
// Decoder/hazard-unit bundle for the immediate sequencer.
//
// Handshake: an immediate is accepted on a rising clk edge where in_valid and
// in_ready are both high. in_ready is ~stall and does not depend on in_valid.
// flush wins over everything except reset and discards a same-cycle input.
// out_valid/imm_out/prefix_pending are registered and change only on clk.
interface imm_ext_ctrl_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  logic [1:0]       ext_mode;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [OUT_W-1:0] imm_out;
  logic             prefix_pending;

  // Decoder / hazard unit side.
  modport master (
    output in_valid, imm_in, ext_mode, stall, flush,
    input  in_ready, out_valid, imm_out, prefix_pending
  );

  // Sequencer side.
  modport slave (
    input  in_valid, imm_in, ext_mode, stall, flush,
    output in_ready, out_valid, imm_out, prefix_pending
  );

endinterface

// File: rtl/imm_ext_ctrl_extend.sv
// Combinational immediate extender: zero/sign extension, shift-by-a-byte, or
// joining a held HI prefix with the current byte.
module imm_extend
  import imm_ext_ctrl_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]  imm_in,
  input  ext_mode_t        mode,
  input  logic [IN_W-1:0]  hi_reg,
  input  logic             prefix,
  output logic [OUT_W-1:0] ext_out
);

  // A pending prefix overrides the mode; otherwise the mode selects the extension.
  always_comb begin
    ext_out = '0;
    if (prefix) begin
      ext_out = {hi_reg, imm_in};
    end else begin
      case (mode)
        EXT_ZERO: ext_out = {{IN_W{1'b0}}, imm_in};
        EXT_SIGN: ext_out = {{IN_W{imm_in[IN_W-1]}}, imm_in};
        EXT_SHL8: ext_out = {imm_in, {IN_W{1'b0}}};
        // HI with no prefix only loads hi_reg; the value here is never registered.
        default:  ext_out = {{IN_W{1'b0}}, imm_in};
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_ctrl.sv
// ID-stage immediate sequencer: extends one byte per accepted instruction into
// the 16-bit ID/EX immediate slot, with HI-prefix joining, stall and flush.
module imm_ext_ctrl
  import imm_ext_ctrl_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W   // must be 2*IN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  imm_ext_ctrl_if.slave   bus,
  output logic            dbgState,
  output logic [IN_W-1:0] dbgHiReg
);

  logic [0:0]       stateQ;
  logic [IN_W-1:0]  hiReg;
  logic [OUT_W-1:0] immOutQ;
  logic             outValidQ;
  logic [OUT_W-1:0] extOut;
  logic             accept;
  logic             modeIsHi;

  // Ready is purely the inverse of stall so the decoder never waits on data.
  assign bus.in_ready = ~bus.stall;
  assign accept       = bus.in_valid & bus.in_ready;
  assign modeIsHi     = isPrefixMode(bus.ext_mode);

  imm_extend #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) uExtend (
    .imm_in  (bus.imm_in),
    .mode    (bus.ext_mode),
    .hi_reg  (hiReg),
    .prefix  (stateQ == S_PREFIX),
    .ext_out (extOut)
  );

  // Sequencer state, prefix byte and ID/EX immediate register; priority is
  // reset > flush > stall > accept > bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= S_IDLE;
      hiReg     <= '0;
      immOutQ   <= '0;
      outValidQ <= 1'b0;
    end else if (bus.flush) begin
      // Squash the slot and drop any half-built prefix; imm_out keeps its value.
      stateQ    <= S_IDLE;
      outValidQ <= 1'b0;
    end else if (bus.stall) begin
      // Hold everything for the hazard unit.
      stateQ    <= stateQ;
    end else if (accept) begin
      case (stateQ)
        S_IDLE: begin
          if (modeIsHi) begin
            hiReg     <= bus.imm_in;
            stateQ    <= S_PREFIX;
            outValidQ <= 1'b0;
          end else begin
            immOutQ   <= extOut;
            outValidQ <= 1'b1;
          end
        end
        default: begin
          // A second HI replaces the held prefix; any other mode completes it.
          if (modeIsHi) begin
            hiReg     <= bus.imm_in;
            outValidQ <= 1'b0;
          end else begin
            immOutQ   <= extOut;
            outValidQ <= 1'b1;
            stateQ    <= S_IDLE;
          end
        end
      endcase
    end else begin
      outValidQ <= 1'b0;
    end
  end

  assign bus.out_valid      = outValidQ;
  assign bus.imm_out        = immOutQ;
  assign bus.prefix_pending = (stateQ == S_PREFIX);

  assign dbgState = stateQ;
  assign dbgHiReg = hiReg;

endmodule
